// File: rtl/seq_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: default widths,
// opcode values, FSM state encoding and the pc-next selector.
package seq_control_unit_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_SEL_W  = 3;
  localparam int OPC_W      = 8 - DEF_SEL_W;

  localparam logic [OPC_W-1:0] OP_NOP      = 5'b00000;
  localparam logic [OPC_W-1:0] OP_MOV_TO0  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_MOV_FR0  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ALU      = 5'b00011;
  localparam logic [OPC_W-1:0] OP_LDI      = 5'b00100;
  localparam logic [OPC_W-1:0] OP_JMP      = 5'b00101;
  localparam logic [OPC_W-1:0] OP_JZ       = 5'b00110;
  localparam logic [OPC_W-1:0] OP_HLT      = 5'b11111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_e;

  // Instructions whose operand byte is read during EXEC.
  function automatic logic is_two_byte(input logic [OPC_W-1:0] opc);
    return (opc == OP_LDI) || (opc == OP_JMP) || (opc == OP_JZ);
  endfunction

endpackage

// File: rtl/seq_control_unit_if.sv
// Control-unit bus: program-memory handshake in, datapath controls out.
interface seq_control_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 3
);
  logic [7:0]        inst;
  logic              memReady;
  logic              zero;
  logic [ADDR_W-1:0] memAddr;
  logic [SEL_W-1:0]  aluSel;
  logic [SEL_W-1:0]  regInSel;
  logic [SEL_W-1:0]  regOutSel;
  logic              regInEn;
  logic              regOutEn;
  logic              genConst;
  logic [DATA_W-1:0] constOut;
  logic              halted;
  logic              illegal;

  modport master (
    input  inst, memReady, zero,
    output memAddr, aluSel, regInSel, regOutSel, regInEn, regOutEn,
           genConst, constOut, halted, illegal
  );

  modport slave (
    output inst, memReady, zero,
    input  memAddr, aluSel, regInSel, regOutSel, regInEn, regOutEn,
           genConst, constOut, halted, illegal
  );
endinterface

// File: rtl/seq_control_unit_cu_decode.sv
// Combinational instruction decode for the EXEC cycle; every output is idle
// unless active is set.
module cu_decode
  import seq_control_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic              active,
  input  logic [7:0]        ir,
  input  logic [7:0]        inst,
  input  logic              mem_ready,
  input  logic              zero,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [SEL_W-1:0]  reg_in_sel,
  output logic [SEL_W-1:0]  reg_out_sel,
  output logic              reg_in_en,
  output logic              reg_out_en,
  output logic              gen_const,
  output logic [DATA_W-1:0] const_val,
  output pc_sel_e           pc_sel,
  output logic              wait_operand,
  output logic              halt,
  output logic              illegal
);

  logic [7-SEL_W:0] opcode;
  logic [SEL_W-1:0] operand_sel;

  assign opcode      = ir[7:SEL_W];
  assign operand_sel = ir[SEL_W-1:0];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    alu_sel      = '0;
    reg_in_sel   = '0;
    reg_out_sel  = '0;
    reg_in_en    = 1'b0;
    reg_out_en   = 1'b0;
    gen_const    = 1'b0;
    const_val    = '0;
    pc_sel       = PC_HOLD;
    wait_operand = 1'b0;
    halt         = 1'b0;
    illegal      = 1'b0;

    if (active) begin
      wait_operand = is_two_byte(opcode) && !mem_ready;
      case (opcode)
        OP_NOP: ;
        OP_MOV_TO0: begin
          reg_out_sel = operand_sel;
          reg_in_en   = 1'b1;
          reg_out_en  = 1'b1;
        end
        OP_MOV_FR0: begin
          reg_in_sel = operand_sel;
          reg_in_en  = 1'b1;
          reg_out_en = 1'b1;
        end
        OP_ALU: begin
          alu_sel     = operand_sel;
          reg_out_sel = SEL_W'(1);
          reg_in_en   = 1'b1;
          reg_out_en  = 1'b1;
        end
        OP_LDI: if (mem_ready) begin
          reg_in_sel = operand_sel;
          reg_in_en  = 1'b1;
          gen_const  = 1'b1;
          const_val  = DATA_W'(inst);
          pc_sel     = PC_INC;
        end
        OP_JMP: if (mem_ready) pc_sel = PC_TARGET;
        OP_JZ:  if (mem_ready) pc_sel = zero ? PC_TARGET : PC_INC;
        OP_HLT: halt = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit: owns pc, ir and the FETCH/EXEC/HALT sequencer,
// and drives datapath controls through the cu_decode block.
module seq_control_unit
  import seq_control_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input logic                clk,
  input logic                rst,
  seq_control_unit_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;

  logic    exec_active;
  pc_sel_e pc_sel;
  logic    wait_operand;
  logic    halt;

  // Reset gates the controls combinationally so an aborted instruction
  // never writes the register file in the reset cycle.
  assign exec_active = (state_q == ST_EXEC) && !rst;

  cu_decode #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_decode (
    .active       (exec_active),
    .ir           (ir_q),
    .inst         (bus.inst),
    .mem_ready    (bus.memReady),
    .zero         (bus.zero),
    .alu_sel      (bus.aluSel),
    .reg_in_sel   (bus.regInSel),
    .reg_out_sel  (bus.regOutSel),
    .reg_in_en    (bus.regInEn),
    .reg_out_en   (bus.regOutEn),
    .gen_const    (bus.genConst),
    .const_val    (bus.constOut),
    .pc_sel       (pc_sel),
    .wait_operand (wait_operand),
    .halt         (halt),
    .illegal      (bus.illegal)
  );

  assign bus.memAddr = pc_q;
  assign bus.halted  = (state_q == ST_HALT) && !rst;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: if (bus.memReady) begin
        ir_d    = bus.inst;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (halt)              state_d = ST_HALT;
        else if (!wait_operand) state_d = ST_FETCH;
        case (pc_sel)
          PC_INC:    pc_d = pc_q + ADDR_W'(1);
          PC_TARGET: pc_d = ADDR_W'(bus.inst);
          default:   ;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge value of the others.
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: directed vector table, then a random program
// run against an instruction-level reference interpreter.
module tb_seq_control_unit;

  typedef struct packed {
    logic [7:0] addr;
    logic [2:0] alu;
    logic [2:0] rin;
    logic [2:0] rout;
    logic       ien;
    logic       oen;
    logic       gc;
    logic [7:0] cval;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct {
    logic       rst;
    logic [7:0] inst;
    logic       ready;
    logic       zero;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_control_unit_if #(.DATA_W(8), .ADDR_W(8), .SEL_W(3)) bus ();

  seq_control_unit #(.DATA_W(8), .ADDR_W(8), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic out_t mk(input logic [7:0] a, input logic [2:0] alu,
                              input logic [2:0] rin, input logic [2:0] rout,
                              input logic ien, input logic oen, input logic gc,
                              input logic [7:0] cv, input logic h, input logic ill);
    out_t o;
    o.addr = a; o.alu = alu; o.rin = rin; o.rout = rout;
    o.ien = ien; o.oen = oen; o.gc = gc; o.cval = cv;
    o.halted = h; o.illegal = ill;
    return o;
  endfunction

  function automatic out_t idle(input logic [7:0] a);
    return mk(a, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endfunction

  function automatic out_t sample();
    return mk(bus.memAddr, bus.aluSel, bus.regInSel, bus.regOutSel,
              bus.regInEn, bus.regOutEn, bus.genConst, bus.constOut,
              bus.halted, bus.illegal);
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got addr=%h alu=%0d rin=%0d rout=%0d ien=%b oen=%b gc=%b c=%h h=%b ill=%b ; want addr=%h alu=%0d rin=%0d rout=%0d ien=%b oen=%b gc=%b c=%h h=%b ill=%b",
               name, got.addr, got.alu, got.rin, got.rout, got.ien, got.oen, got.gc,
               got.cval, got.halted, got.illegal, exp.addr, exp.alu, exp.rin,
               exp.rout, exp.ien, exp.oen, exp.gc, exp.cval, exp.halted, exp.illegal);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] i, input logic rdy, input logic z);
    rst          = r;
    bus.inst     = i;
    bus.memReady = rdy;
    bus.zero     = z;
  endtask

  // Reference interpreter: instruction-level semantics of the CPU.
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  bit         m_in_exec;
  bit         m_halt;
  logic [7:0] mem [256];

  function automatic bit opc_defined(input int opc);
    return (opc <= 6) || (opc == 31);
  endfunction

  function automatic out_t model_out(input logic r, input logic rdy, input logic z,
                                     input logic [7:0] i);
    out_t o;
    int   opc;
    logic [2:0] rr;
    o   = idle(m_pc);
    opc = int'(m_ir) / 8;
    rr  = m_ir[2:0];
    if (r) return o;
    if (m_halt) begin
      o.halted = 1'b1;
    end else if (m_in_exec) begin
      if (!opc_defined(opc)) o.illegal = 1'b1;
      if (opc == 1) begin o.rout = rr; o.ien = 1'b1; o.oen = 1'b1; end
      if (opc == 2) begin o.rin = rr;  o.ien = 1'b1; o.oen = 1'b1; end
      if (opc == 3) begin o.alu = rr; o.rout = 3'd1; o.ien = 1'b1; o.oen = 1'b1; end
      if (opc == 4 && rdy) begin o.rin = rr; o.ien = 1'b1; o.gc = 1'b1; o.cval = i; end
    end
    return o;
  endfunction

  task automatic model_step(input logic r, input logic rdy, input logic z,
                            input logic [7:0] i);
    int opc;
    opc = int'(m_ir) / 8;
    if (r) begin
      m_pc = 8'h00; m_ir = 8'h00; m_in_exec = 0; m_halt = 0;
    end else if (m_halt) begin
    end else if (!m_in_exec) begin
      if (rdy) begin m_ir = i; m_pc = 8'((int'(m_pc) + 1) % 256); m_in_exec = 1; end
    end else if (opc >= 4 && opc <= 6) begin
      if (rdy) begin
        if (opc == 5 || (opc == 6 && z)) m_pc = i;
        else                             m_pc = 8'((int'(m_pc) + 1) % 256);
        m_in_exec = 0;
      end
    end else begin
      m_in_exec = 0;
      if (opc == 31) m_halt = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   opc_pick [12];
    int   halt_cycles;

    vecs.push_back('{1'b1, 8'hFF, 1'b1, 1'b0, idle(8'h00)});
    vecs.push_back('{1'b0, 8'h0B, 1'b1, 1'b0, idle(8'h00)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, mk(8'h01, 0, 0, 3, 1, 1, 0, 8'h00, 0, 0)});
    vecs.push_back('{1'b0, 8'h22, 1'b1, 1'b0, idle(8'h01)});
    vecs.push_back('{1'b0, 8'hA5, 1'b0, 1'b0, idle(8'h02)});
    vecs.push_back('{1'b0, 8'hA5, 1'b0, 1'b0, idle(8'h02)});
    vecs.push_back('{1'b0, 8'hA5, 1'b1, 1'b0, mk(8'h02, 0, 2, 0, 1, 0, 1, 8'hA5, 0, 0)});
    vecs.push_back('{1'b0, 8'h30, 1'b1, 1'b0, idle(8'h03)});
    vecs.push_back('{1'b0, 8'h40, 1'b1, 1'b0, idle(8'h04)});
    vecs.push_back('{1'b0, 8'h30, 1'b1, 1'b1, idle(8'h05)});
    vecs.push_back('{1'b0, 8'h40, 1'b1, 1'b1, idle(8'h06)});
    vecs.push_back('{1'b0, 8'h28, 1'b1, 1'b0, idle(8'h40)});
    vecs.push_back('{1'b0, 8'hFE, 1'b1, 1'b0, idle(8'h41)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, idle(8'hFE)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, idle(8'hFF)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, idle(8'hFF)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, idle(8'h00)});
    vecs.push_back('{1'b0, 8'h40, 1'b1, 1'b0, idle(8'h00)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, mk(8'h01, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1)});
    vecs.push_back('{1'b0, 8'hFF, 1'b1, 1'b0, idle(8'h01)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, idle(8'h02)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, mk(8'h02, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0)});
    vecs.push_back('{1'b0, 8'h0B, 1'b1, 1'b1, mk(8'h02, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0)});
    vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, idle(8'h02)});
    vecs.push_back('{1'b0, 8'h22, 1'b1, 1'b0, idle(8'h00)});
    vecs.push_back('{1'b1, 8'h77, 1'b1, 1'b0, idle(8'h01)});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, idle(8'h00)});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, idle(8'h00)});
    vecs.push_back('{1'b0, 8'h19, 1'b1, 1'b0, idle(8'h00)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, mk(8'h01, 1, 0, 1, 1, 1, 0, 8'h00, 0, 0)});
    vecs.push_back('{1'b0, 8'h15, 1'b1, 1'b0, idle(8'h01)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, mk(8'h02, 0, 5, 0, 1, 1, 0, 8'h00, 0, 0)});

    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    @(posedge clk); #1;

    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v].rst, vecs[v].inst, vecs[v].ready, vecs[v].zero);
      #3;
      check($sformatf("vec%0d", v), sample(), vecs[v].exp);
      @(posedge clk); #1;
    end

    // Random program run: inst is fetched from the model's own pc.
    opc_pick = '{0, 1, 2, 3, 4, 5, 6, 1, 3, 4, 6, 8};
    for (int a = 0; a < 256; a++) begin
      int pick;
      pick = $urandom_range(0, 60);
      if (pick == 0)       mem[a] = {5'b11111, 3'($urandom_range(0, 7))};
      else if (pick < 12)  mem[a] = 8'($urandom);
      else                 mem[a] = {5'(opc_pick[$urandom_range(0, 11)]), 3'($urandom_range(0, 7))};
    end

    drive(1'b1, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    m_pc = 8'h00; m_ir = 8'h00; m_in_exec = 0; m_halt = 0;
    halt_cycles = 0;

    for (int c = 0; c < 3000; c++) begin
      logic       r, rdy, z;
      logic [7:0] i;
      out_t       exp;
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
      r   = (halt_cycles > 3) || ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      z   = 1'($urandom_range(0, 1));
      i   = mem[m_pc];
      drive(r, i, rdy, z);
      #3;
      exp = model_out(r, rdy, z, i);
      check($sformatf("rand%0d", c), sample(), exp);
      @(posedge clk); #1;
      model_step(r, rdy, z, i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
